// File: rtl/bcd_down_timer.sv
// ============================================================================
// Module   : bcd_down_timer
// Brief    : Multi-digit packed-BCD countdown timer with pause and auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_timer #(
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  localparam int              c_width     = 4 * DIGITS;
  localparam logic [1:0]      c_st_idle   = 2'd0;
  localparam logic [1:0]      c_st_run    = 2'd1;
  localparam logic [1:0]      c_st_paused = 2'd2;
  localparam logic [1:0]      c_st_done   = 2'd3;
  localparam logic [c_width-1:0] c_one    = {{(c_width-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [c_width-1:0] r_count;
  logic [c_width-1:0] r_preset;
  logic               r_done;
  logic               r_running;
  logic               r_reload;

  logic [1:0]         w_state_nxt;
  logic [c_width-1:0] w_count_nxt;
  logic [c_width-1:0] w_preset_nxt;
  logic               w_done_nxt;
  logic               w_reload_nxt;

  logic [c_width-1:0] w_sat_val;
  logic [c_width-1:0] w_dec_val;
  logic [DIGITS-1:0]  w_borrow;
  logic               w_count_zero;
  logic               w_step;
  logic               w_expire;
  logic               w_reload_go;

  // Per-digit saturation of the preset and borrow-rippled decrement.
  assign w_borrow[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_cur;
      logic [3:0] w_in;
      assign w_cur = r_count[4*gi +: 4];
      assign w_in  = load_val[4*gi +: 4];
      assign w_sat_val[4*gi +: 4] = (w_in > 4'd9) ? 4'd9 : w_in;
      assign w_dec_val[4*gi +: 4] = !w_borrow[gi]     ? w_cur :
                                    (w_cur == 4'd0)   ? 4'd9  : w_cur - 4'd1;
      if (gi < DIGITS - 1) begin : g_chain
        assign w_borrow[gi+1] = w_borrow[gi] && (w_cur == 4'd0);
      end
    end
  endgenerate

  assign w_count_zero = (r_count == '0);
  // A pending reload cycle swallows ticks so the zero value is visible once.
  assign w_step       = (r_state == c_st_run) && tick && !pause && !r_reload && !w_count_zero;
  assign w_expire     = w_step && (r_count == c_one);
  assign w_reload_go  = w_expire && (AUTO_RELOAD != 0) && (r_preset != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_count   <= '0;
      r_preset  <= '0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
      r_reload  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_preset  <= w_preset_nxt;
      r_done    <= w_done_nxt;
      r_running <= (w_state_nxt == c_st_run);
      r_reload  <= w_reload_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle, c_st_paused: begin
          if (start && !pause && !w_count_zero) w_state_nxt = c_st_run;
        end
        c_st_run: begin
          if (pause)                        w_state_nxt = c_st_paused;
          else if (w_expire && !w_reload_go) w_state_nxt = c_st_done;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_count_nxt  = r_count;
    w_preset_nxt = r_preset;
    w_done_nxt   = 1'b0;
    w_reload_nxt = 1'b0;
    if (load) begin
      w_count_nxt  = w_sat_val;
      w_preset_nxt = w_sat_val;
    end else if (r_reload) begin
      w_count_nxt = r_preset;
    end else if (w_expire) begin
      w_count_nxt  = '0;
      w_done_nxt   = 1'b1;
      w_reload_nxt = w_reload_go;
    end else if (w_step) begin
      w_count_nxt = w_dec_val;
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign done    = r_done;
  assign zero    = w_count_zero;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
// ============================================================================
// Module   : tb_bcd_down_timer
// Brief    : Directed bench for bcd_down_timer (2-digit, 3-digit, auto-reload).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        tick = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [11:0] load_val3 = 12'h000;

  logic [7:0]  count_a;
  logic        running_a, zero_a, done_a;
  logic [11:0] count_b;
  logic        running_b, zero_b, done_b;
  logic [7:0]  count_c;
  logic        running_c, zero_c, done_c;

  int errors = 0;
  int checks = 0;

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count_a), .running(running_a),
    .zero(zero_a), .done(done_a));

  bcd_down_timer #(.DIGITS(3), .AUTO_RELOAD(0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val3), .start(start),
    .pause(pause), .tick(tick), .count(count_b), .running(running_b),
    .zero(zero_b), .done(done_b));

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1)) dut_c (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count_c), .running(running_c),
    .zero(zero_c), .done(done_c));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_start(input logic [7:0] v);
    load_val = v; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count_a !== 8'h00 || running_a !== 1'b0 || done_a !== 1'b0 || zero_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: count=%h run=%b done=%b zero=%b expected 00 0 0 1",
               count_a, running_a, done_a, zero_a);
    end
    checks++;
    if (count_b !== 12'h000 || count_c !== 8'h00 || running_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_bc: count_b=%h count_c=%h run_c=%b expected 000 00 0",
               count_b, count_c, running_c);
    end
  endtask

  task automatic test_countdown();
    logic [7:0] exp;
    do_reset();
    load_start(8'h25);
    checks++;
    if (count_a !== 8'h25 || running_a !== 1'b1) begin
      errors++;
      $display("FAIL start: count=%h run=%b expected 25 1", count_a, running_a);
    end
    for (int k = 1; k <= 25; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
      exp = 8'(((25 - k) / 10) * 16 + ((25 - k) % 10));
      checks++;
      if (count_a !== exp || done_a !== (k == 25)) begin
        errors++;
        $display("FAIL countdown[%0d]: count=%h done=%b expected %h %b",
                 k, count_a, done_a, exp, (k == 25));
      end
    end
    step();
    checks++;
    if (done_a !== 1'b0 || running_a !== 1'b0 || count_a !== 8'h00) begin
      errors++;
      $display("FAIL after_done: count=%h run=%b done=%b expected 00 0 0",
               count_a, running_a, done_a);
    end
    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    checks++;
    if (count_a !== 8'h00 || done_a !== 1'b0 || zero_a !== 1'b1) begin
      errors++;
      $display("FAIL no_wrap: count=%h done=%b zero=%b expected 00 0 1",
               count_a, done_a, zero_a);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (running_a !== 1'b0) begin
      errors++;
      $display("FAIL done_start: run=%b expected 0", running_a);
    end
  endtask

  task automatic test_back_to_back();
    load_start(8'h02);
    tick = 1'b1; step();
    checks++;
    if (count_a !== 8'h01 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reload_from_done1: count=%h done=%b expected 01 0", count_a, done_a);
    end
    step(); tick = 1'b0;
    checks++;
    if (count_a !== 8'h00 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL reload_from_done2: count=%h done=%b expected 00 1", count_a, done_a);
    end
  endtask

  task automatic test_borrow();
    do_reset();
    load_val3 = 12'h100; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (count_b !== 12'h099) begin
      errors++;
      $display("FAIL borrow1: count=%h expected 099", count_b);
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (count_b !== 12'h098) begin
      errors++;
      $display("FAIL borrow2: count=%h expected 098", count_b);
    end
  endtask

  task automatic test_pause();
    do_reset();
    load_start(8'h50);
    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    checks++;
    if (count_a !== 8'h47) begin
      errors++;
      $display("FAIL pre_pause: count=%h expected 47", count_a);
    end
    pause = 1'b1; tick = 1'b1; step(); pause = 1'b0;
    step(); step(); step(); step(); step(); tick = 1'b0;
    checks++;
    if (count_a !== 8'h47 || running_a !== 1'b0) begin
      errors++;
      $display("FAIL paused: count=%h run=%b expected 47 0", count_a, running_a);
    end
    start = 1'b1; step(); start = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (count_a !== 8'h46 || running_a !== 1'b1) begin
      errors++;
      $display("FAIL resume: count=%h run=%b expected 46 1", count_a, running_a);
    end
    pause = 1'b1; step();
    start = 1'b1; step(); start = 1'b0; pause = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (count_a !== 8'h46 || running_a !== 1'b0) begin
      errors++;
      $display("FAIL start_pause: count=%h run=%b expected 46 0", count_a, running_a);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    load_val = 8'hA3; load = 1'b1; step(); load = 1'b0;
    checks++;
    if (count_a !== 8'h93 || running_a !== 1'b0) begin
      errors++;
      $display("FAIL sat_load: count=%h run=%b expected 93 0", count_a, running_a);
    end
    load_val = 8'h3F; load = 1'b1; step(); load = 1'b0;
    checks++;
    if (count_a !== 8'h39) begin
      errors++;
      $display("FAIL sat_low: count=%h expected 39", count_a);
    end
    start = 1'b1; step(); start = 1'b0;
    load_val = 8'h12; load = 1'b1; tick = 1'b1; step(); load = 1'b0;
    checks++;
    if (count_a !== 8'h12 || running_a !== 1'b0) begin
      errors++;
      $display("FAIL load_tick: count=%h run=%b expected 12 0", count_a, running_a);
    end
    step(); tick = 1'b0;
    checks++;
    if (count_a !== 8'h12) begin
      errors++;
      $display("FAIL idle_tick: count=%h expected 12", count_a);
    end
    load_val = 8'h00; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (running_a !== 1'b0 || count_a !== 8'h00) begin
      errors++;
      $display("FAIL start_zero: count=%h run=%b expected 00 0", count_a, running_a);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    load_start(8'h37);
    rst = 1'b1; tick = 1'b1; step(); rst = 1'b0; tick = 1'b0;
    checks++;
    if (count_a !== 8'h00 || running_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_midrun: count=%h run=%b done=%b expected 00 0 0",
               count_a, running_a, done_a);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (running_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_start: run=%b expected 0", running_a);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_c [4] = '{8'h02, 8'h01, 8'h00, 8'h03};
    logic       exp_d [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    load_start(8'h03);
    tick = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (count_c !== exp_c[k] || done_c !== exp_d[k] || running_c !== 1'b1) begin
        errors++;
        $display("FAIL auto_reload[%0d]: count=%h done=%b run=%b expected %h %b 1",
                 k, count_c, done_c, running_c, exp_c[k], exp_d[k]);
      end
    end
    step(); tick = 1'b0;
    checks++;
    if (count_c !== 8'h02 || running_c !== 1'b1) begin
      errors++;
      $display("FAIL auto_next: count=%h run=%b expected 02 1", count_c, running_c);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_back_to_back();
    test_borrow();
    test_pause();
    test_load_priority();
    test_reset_midrun();
    test_auto_reload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
